// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_pipe_pkg : shared types and constants for the RISC-V pipeline stages   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package rv_pipe_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_buffer : fetched-instruction FIFO with push/pop/flush               |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module fetch_buffer
  import rv_pipe_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_pkt_t    push_pkt,
  input  logic          pop,
  input  logic          flush,
  output fetch_pkt_t    head_pkt,
  output logic [CW-1:0] count
);

  fetch_pkt_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wptr] <= push_pkt;
  end

  assign head_pkt = r_mem[r_rptr];
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_unit : PC owner, imem request issue and decode hand-off       |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter int              XLEN     = rv_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pipe_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  import rv_pipe_pkg::*;

  localparam int            CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);

  logic            r_run;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_credit_used;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_req_fire;
  logic            w_pop;
  logic            w_push;
  fetch_pkt_t      w_head;
  fetch_pkt_t      w_push_pkt;

  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign id_valid   = (w_count != '0);
  assign w_pop      = id_valid && id_ready;

  // A pop this cycle frees a slot, so one fetch per cycle is sustained at DEPTH=2.
  assign w_credit_used  = r_outstanding + w_count - {{(CW-1){1'b0}}, w_pop};
  assign imem_req_valid = r_run && !redirect_valid && (w_credit_used < c_depth_cnt);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_push     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_push_pkt = '{instr: imem_rsp_data, pc: r_rsp_pc};

  always_comb begin
    w_out_next = r_outstanding;
    if (w_req_fire && !imem_rsp_valid)      w_out_next = r_outstanding + CW'(1);
    else if (!w_req_fire && imem_rsp_valid) w_out_next = r_outstanding - CW'(1);
  end

  // r_rsp_pc tracks the PC of the next response that will be kept, since
  // every kept request since the last redirect is sequential.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_pc     <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_drop   <= w_out_next;
      end else begin
        if (w_req_fire) r_pc <= r_pc + XLEN'(4);
        if (w_push)     r_rsp_pc <= r_rsp_pc + XLEN'(4);
        if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      end
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_pkt (w_push_pkt),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .head_pkt (w_head),
    .count    (w_count)
  );

  assign id_instr    = id_valid ? w_head.instr : NOP_INSTR;
  assign id_pc       = id_valid ? w_head.pc    : RESET_PC;
  assign id_pc_plus4 = id_pc + XLEN'(4);

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch stage of the 5-stage RISC-V pipeline: the producer side of the instruction stream that the decode stage and its main decoder consume. It owns the PC, issues word requests to instruction memory over a valid/ready request channel with in-order responses, buffers returned instructions, and hands `{instr, pc, pc_plus4}` to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard in-flight stale responses.

## Interface
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of two, >= 2)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  XLEN  word address, bits [1:0] always 0
- `imem_req_ready`  in  1  memory accepts request
- `imem_rsp_valid`  in  1  response valid, always accepted, in request order
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  taken branch/jump from execute
- `redirect_pc`  in  XLEN  redirect target
- `id_valid`  out  1  instruction available to decode
- `id_ready`  in  1  decode accepts (low = stall)
- `id_instr`  out  32  instruction word
- `id_pc`  out  XLEN  PC of `id_instr`
- `id_pc_plus4`  out  XLEN  `id_pc + 4`, modulo 2^XLEN

## Operation
- State: `pc` (next address to request), buffer (`DEPTH` entries of `{instr, pc}`), `outstanding` counter, `drop` counter.
- Issue: `imem_req_valid = !redirect_valid && (outstanding + count < DEPTH)`; request address is `pc`. On accept (`valid && ready`): `pc <= pc + 4` (wraps at 2^XLEN), `outstanding++`.
- Response: if `drop > 0`, discard and `drop--`; else push `{imem_rsp_data, pc-of-oldest-outstanding}` into buffer. `outstanding--` in either case. Request PCs of outstanding fetches kept in a small `DEPTH`-entry tag queue (or derived from buffer tail PC + 4).
- Credit rule guarantees a non-dropped response never finds the buffer full; no backpressure on `imem_rsp`.
- Decode handshake: `id_*` driven from buffer head; pop on `id_valid && id_ready`. Push and pop in the same cycle allowed at any occupancy, including full.
- Redirect (priority over everything): buffer cleared, `pc <= {redirect_pc[XLEN-1:2], 2'b00}`, `drop <= outstanding - (response this cycle ? 1 : 0)`, `outstanding` keeps that same value for accounting. A response arriving in the redirect cycle is discarded. A pop in the redirect cycle still counts as accepted by decode.
- Redirect while `drop > 0`: drop accumulates, all older responses discarded.

## Timing
- Reset values: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `id_valid=0`, `id_instr=32'h0000_0013` (NOP), `id_pc=RESET_PC`, `id_pc_plus4=RESET_PC+4`; counters 0, buffer empty.
- First request: first rising edge after `rst_n` deasserts drives `imem_req_valid=1`, addr `RESET_PC`.
- Response at edge N -> `id_valid=1` with that instruction from cycle N+1 (registered buffer); no combinational path from `imem_rsp_*` or `redirect_*` to `id_*`.
- Redirect asserted in cycle N -> `id_valid=0` in N+1; request for target issued from N+1 (`imem_req_valid` combinationally low during N).
- Full throughput with 1-cycle memory latency and `id_ready=1`: one instruction per cycle sustained.
- Reset asserted mid-operation: all state returns to reset values immediately; later responses to pre-reset requests are the memory's responsibility to squash.

## Structure
- Shared package `rv_pipe_pkg`: `XLEN`, `NOP_INSTR = 32'h0000_0013`, `RESET_PC` default, typedef `fetch_pkt_t {instr, pc}`.
- One sub-module: `fetch_buffer` — parameterised synchronous FIFO (`DEPTH`, `fetch_pkt_t`) with push/pop/flush, count output, simultaneous push+pop when full.

## Test plan
- Reset then 1-cycle memory, `id_ready=1`: PCs 0x0, 0x4, 0x8… on consecutive cycles, first `id_valid` 2 cycles after first request accept.
- `id_ready=0` for 10 cycles: at most 2 requests issued, buffer holds PCs 0x0, 0x4, `imem_req_valid=0`; release -> 0x0, 0x4, 0x8 in order, none lost or duplicated.
- 3-cycle memory latency, redirect to 0x100 with 2 outstanding: both stale responses dropped, next `id_pc` = 0x100.
- Redirect to 0x203 in same cycle as a response: response discarded, request addr 0x200, `id_pc` 0x200.
- PC wrap: redirect to 0xFFFF_FFFC -> next fetch 0x0, `id_pc_plus4` = 0x0.
- Assert `rst_n=0` with buffer full and 1 outstanding: `id_valid=0`, `imem_req_valid=0` immediately; after release, fetch restarts at `RESET_PC`.
